// File: rtl/spi_byte_ser_pkg.sv
// Shared word-format constants and FSM state type for the SPI byte serializer.
package spi_byte_ser_pkg;

  localparam logic [1:0] KIND_DATA  = 2'b00;
  localparam logic [1:0] KIND_CLEAR = 2'b01;

  localparam int KIND_MSB = 31;
  localparam int KIND_LSB = 30;
  localparam int CNT_MSB  = 25;
  localparam int CNT_LSB  = 24;
  localparam int PAY_W    = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CLR  = 2'd2
  } state_t;

  function automatic logic [7:0] pick_byte(input logic [PAY_W-1:0] payload,
                                           input logic [1:0]       idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = payload[7:0];
      2'd1:    b = payload[15:8];
      default: b = payload[23:16];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_serializer.sv
// Splits 32-bit SPI send words into 1..3 payload bytes (LSB first) for crc32,
// emits a one-cycle CRC clear on CLEAR words and counts dropped words.
module spi_byte_serializer
  import spi_byte_ser_pkg::*;
#(
  parameter int nbits    = 32,
  parameter int cnt_bits = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  input  logic [nbits-1:0]    in_msg,
  output logic                in_rdy,
  output logic                out_val,
  output logic [7:0]          out_msg,
  input  logic                out_rdy,
  output logic                crc_clear,
  output logic [cnt_bits-1:0] err_count,
  output logic                busy
);

  localparam logic [cnt_bits-1:0] ERR_ONE = {{(cnt_bits-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [PAY_W-1:0]    r_payload;
  logic [1:0]          r_count;
  logic [1:0]          r_idx;
  logic                r_out_val;
  logic [7:0]          r_out_msg;
  logic                r_crc_clear;
  logic [cnt_bits-1:0] r_err;

  logic [1:0] w_kind;
  logic [1:0] w_cnt;
  logic       w_last;
  logic       w_is_data;
  logic       w_is_clear;
  logic       w_accept;
  logic       w_unused_bits;

  assign w_kind        = in_msg[KIND_MSB:KIND_LSB];
  assign w_cnt         = in_msg[CNT_MSB:CNT_LSB];
  assign w_is_data     = (w_kind == KIND_DATA) && (w_cnt != 2'd0);
  assign w_is_clear    = (w_kind == KIND_CLEAR);
  assign w_last        = (r_idx == (r_count - 2'd1));
  assign w_unused_bits = ^in_msg[29:26];

  // Ready on the last byte's handoff too, so words stream without a bubble.
  assign in_rdy   = reset && ((r_state == IDLE) ||
                              ((r_state == SEND) && w_last && out_rdy));
  assign w_accept = in_val && in_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_payload   <= '0;
      r_count     <= 2'd0;
      r_idx       <= 2'd0;
      r_out_val   <= 1'b0;
      r_out_msg   <= 8'h00;
      r_crc_clear <= 1'b0;
      r_err       <= '0;
    end else if (w_accept) begin
      if (w_is_data) begin
        r_payload <= in_msg[PAY_W-1:0];
        r_count   <= w_cnt;
        r_idx     <= 2'd0;
        r_out_msg <= in_msg[7:0];
        r_out_val <= 1'b1;
        r_state   <= SEND;
      end else if (w_is_clear) begin
        r_out_val   <= 1'b0;
        r_crc_clear <= 1'b1;
        r_state     <= CLR;
      end else begin
        r_out_val <= 1'b0;
        r_state   <= IDLE;
        if (r_err != '1) r_err <= r_err + ERR_ONE;
      end
    end else begin
      case (r_state)
        SEND: begin
          if (out_rdy) begin
            if (!w_last) begin
              r_idx     <= r_idx + 2'd1;
              r_out_msg <= pick_byte(r_payload, r_idx + 2'd1);
            end else begin
              r_out_val <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
        CLR: begin
          r_crc_clear <= 1'b0;
          r_state     <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign out_val   = r_out_val;
  assign out_msg   = r_out_msg;
  assign crc_clear = r_crc_clear;
  assign err_count = r_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_spi_byte_serializer.sv
// Bench for spi_byte_serializer: directed vector table, hand sequences and a
// randomized run checked against a byte-queue reference model.
module tb_spi_byte_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic [31:0] in_msg;
  logic        in_rdy;
  logic        out_val;
  logic [7:0]  out_msg;
  logic        out_rdy;
  logic        crc_clear;
  logic [7:0]  err_count;
  logic        busy;

  always #5 clk = ~clk;

  spi_byte_serializer #(.nbits(32), .cnt_bits(8)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_msg(in_msg), .in_rdy(in_rdy),
    .out_val(out_val), .out_msg(out_msg), .out_rdy(out_rdy),
    .crc_clear(crc_clear), .err_count(err_count), .busy(busy)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: queue of bytes still owed downstream, pending clear, error count.
  logic [7:0] mq[$];
  bit         m_clr;
  int         m_err;

  typedef struct {
    logic       v;
    logic [31:0] m;
    logic       r;
    logic       e_rdy;
    logic       e_val;
    logic [7:0] e_msg;
    logic       e_clr;
    logic [7:0] e_err;
    logic       e_busy;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_rdy(input logic r);
    return (!m_clr && mq.size() == 0) || (mq.size() == 1 && r);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_clr = 1'b0;
    m_err = 0;
  endtask

  task automatic model_check();
    logic busy_exp;
    busy_exp = (mq.size() != 0) || m_clr;
    chk("model in_rdy", 32'(in_rdy), 32'(m_rdy(out_rdy)));
    chk("model out_val", 32'(out_val), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("model out_msg", 32'(out_msg), 32'(mq[0]));
    chk("model crc_clear", 32'(crc_clear), 32'(m_clr));
    chk("model err_count", 32'(err_count), 32'(m_err));
    chk("model busy", 32'(busy), 32'(busy_exp));
  endtask

  task automatic model_edge();
    logic       acc;
    logic [1:0] kind;
    int         cnt;
    acc = in_val && m_rdy(out_rdy);
    if (mq.size() != 0 && out_rdy) void'(mq.pop_front());
    m_clr = 1'b0;
    if (acc) begin
      kind = in_msg[31:30];
      cnt  = int'(in_msg[25:24]);
      if (kind == 2'b00 && cnt != 0) begin
        for (int i = 0; i < cnt; i++) mq.push_back(in_msg[8*i +: 8]);
      end else if (kind == 2'b01) begin
        m_clr = 1'b1;
      end else if (m_err < 255) begin
        m_err++;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] m, input logic r);
    in_val  = v;
    in_msg  = m;
    out_rdy = r;
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] m, input logic r,
                              input logic e_rdy, input logic e_val, input logic [7:0] e_msg,
                              input logic e_clr, input logic [7:0] e_err, input logic e_busy);
    vec_t t;
    t.v = v; t.m = m; t.r = r; t.e_rdy = e_rdy; t.e_val = e_val; t.e_msg = e_msg;
    t.e_clr = e_clr; t.e_err = e_err; t.e_busy = e_busy;
    return t;
  endfunction

  initial begin
    logic [31:0] w;
    int          sel;

    // v, msg, out_rdy | in_rdy, out_val, out_msg, crc_clear, err, busy
    tbl[0]  = mk(1'b1, 32'h03332211, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tbl[1]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'd0, 1'b1);
    tbl[2]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 8'd0, 1'b1);
    tbl[3]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'd0, 1'b1);
    tbl[4]  = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tbl[5]  = mk(1'b1, 32'h0200BBAA, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tbl[6]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 8'd0, 1'b1);
    tbl[7]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 8'd0, 1'b1);
    tbl[8]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hBB, 1'b0, 8'd0, 1'b1);
    tbl[9]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 8'hBB, 1'b0, 8'd0, 1'b1);
    tbl[10] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 8'hBB, 1'b0, 8'd0, 1'b1);
    tbl[11] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tbl[12] = mk(1'b1, 32'h0100005A, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tbl[13] = mk(1'b1, 32'h010000A5, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 8'd0, 1'b1);
    tbl[14] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'd0, 1'b1);
    tbl[15] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tbl[16] = mk(1'b1, 32'h0100007E, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tbl[17] = mk(1'b1, 32'h40000000, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0, 8'd0, 1'b1);
    tbl[18] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0, 1'b1);
    tbl[19] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tbl[20] = mk(1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tbl[21] = mk(1'b1, 32'hC0000000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1, 1'b0);
    tbl[22] = mk(1'b1, 32'h00123456, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd2, 1'b0);
    tbl[23] = mk(1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd3, 1'b0);

    reset   = 1'b0;
    in_val  = 1'b0;
    in_msg  = 32'h0;
    out_rdy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_rdy", 32'(in_rdy), 32'd0);
    chk("reset out_val", 32'(out_val), 32'd0);
    chk("reset out_msg", 32'(out_msg), 32'd0);
    chk("reset crc_clear", 32'(crc_clear), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].v, tbl[i].m, tbl[i].r);
      chk($sformatf("vec%0d in_rdy", i), 32'(in_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d out_val", i), 32'(out_val), 32'(tbl[i].e_val));
      if (tbl[i].e_val) chk($sformatf("vec%0d out_msg", i), 32'(out_msg), 32'(tbl[i].e_msg));
      chk($sformatf("vec%0d crc_clear", i), 32'(crc_clear), 32'(tbl[i].e_clr));
      chk($sformatf("vec%0d err_count", i), 32'(err_count), 32'(tbl[i].e_err));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      adv();
    end

    // Saturation: 300 more malformed words.
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 2);
      w   = $urandom;
      if (sel == 0)      w = {2'b10, w[29:0]};
      else if (sel == 1) w = {2'b11, w[29:0]};
      else               w = {2'b00, w[29:26], 2'b00, w[23:0]};
      drive(1'b1, w, 1'b1);
      chk("sat no out_val", 32'(out_val), 32'd0);
      adv();
    end
    drive(1'b0, 32'h0, 1'b1);
    chk("err saturated", 32'(err_count), 32'd255);
    adv();

    // Reset in the middle of a three-byte word.
    drive(1'b1, 32'h03CCBBAA, 1'b1);
    adv();
    drive(1'b0, 32'h0, 1'b0);
    chk("midsend byte0", 32'(out_msg), 32'hAA);
    #1;
    reset = 1'b0;
    #1;
    chk("async rst out_val", 32'(out_val), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst err_count", 32'(err_count), 32'd0);
    chk("async rst in_rdy", 32'(in_rdy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 32'h02001122, 1'b1);
    adv();
    drive(1'b0, 32'h0, 1'b1);
    chk("post-rst byte0", 32'(out_msg), 32'h22);
    adv();
    drive(1'b0, 32'h0, 1'b1);
    chk("post-rst byte1", 32'(out_msg), 32'h11);
    adv();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 7);
      w   = $urandom;
      if (sel <= 4)      w[31:30] = 2'b00;
      else if (sel == 5) w[31:30] = 2'b01;
      drive(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 3) != 0));
      adv();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
